// File: rtl/wb_decoder_n.sv
// Wishbone 1-to-N address decoder: routes one master to the lowest-index matching
// slave, terminates unmapped or unresponsive accesses with ERR and logs them.

module wb_dec_match #(
  parameter int                 ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] MASK   = '0
) (
  input  logic [ADDR_W-1:0] adr,
  output logic              hit
);
  assign hit = (adr & MASK) == BASE;
endmodule

module wb_decoder_n #(
  parameter int                       N_SLV    = 4,
  parameter int                       ADDR_W   = 32,
  parameter int                       DATA_W   = 32,
  // slave 3 has a base bit outside its mask, so it never matches
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = {32'h00000001, 32'h00010004, 32'h00010000, 32'h00000000},
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = {32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFF0000},
  parameter int                       TIMEOUT  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_W-1:0]       m_adr,
  input  logic [DATA_W-1:0]       m_dat_o,
  input  logic                    m_we,
  input  logic                    m_cyc,
  input  logic                    m_stb,
  output logic [DATA_W-1:0]       m_dat_i,
  output logic                    m_ack,
  output logic                    m_err,
  output logic [ADDR_W-1:0]       s_adr,
  output logic [DATA_W-1:0]       s_dat_o,
  output logic                    s_we,
  output logic [N_SLV-1:0]        s_cyc,
  output logic [N_SLV-1:0]        s_stb,
  input  logic [N_SLV*DATA_W-1:0] s_dat_i,
  input  logic [N_SLV-1:0]        s_ack,
  output logic [ADDR_W-1:0]       err_addr,
  output logic [7:0]              err_cnt
);
  localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] TERM = 2'd2;

  logic [1:0]       state, state_d;
  logic [SEL_W-1:0] sel, hit_idx;
  logic [15:0]      wcnt;
  logic [N_SLV-1:0] hit;
  logic             any_hit;
  logic             to;
  logic [DATA_W-1:0] sel_dat;

  assign s_adr   = m_adr;
  assign s_dat_o = m_dat_o;
  assign s_we    = m_we;

  for (genvar i = 0; i < N_SLV; i++) begin : g_match
    wb_dec_match #(
      .ADDR_W(ADDR_W),
      .BASE  (SLV_BASE[i*ADDR_W +: ADDR_W]),
      .MASK  (SLV_MASK[i*ADDR_W +: ADDR_W])
    ) u_match (
      .adr(m_adr),
      .hit(hit[i])
    );
  end

  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    any_hit = 1'b0;
    hit_idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign sel_dat = s_dat_i[int'(sel)*DATA_W +: DATA_W];
  assign to      = (wcnt == 16'(TIMEOUT));

  always_comb begin
    state_d = state;
    s_cyc   = '0;
    s_stb   = '0;
    m_ack   = 1'b0;
    m_err   = 1'b0;
    m_dat_i = '0;
    case (state)
      IDLE: if (m_cyc && m_stb) state_d = any_hit ? BUSY : TERM;
      BUSY: begin
        m_dat_i = sel_dat;
        if (!m_cyc)   state_d = IDLE;
        else if (to)  state_d = TERM;
        else begin
          s_cyc[sel] = 1'b1;
          s_stb[sel] = m_stb;
          m_ack      = s_ack[sel];
          if (s_ack[sel]) state_d = IDLE;
        end
      end
      TERM: begin
        m_err   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      sel      <= '0;
      wcnt     <= '0;
      err_addr <= '0;
      err_cnt  <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          wcnt <= '0;
          if (m_cyc && m_stb && any_hit) sel <= hit_idx;
        end
        BUSY: if (m_cyc && !to && !s_ack[sel]) wcnt <= wcnt + 16'd1;
        TERM: begin
          err_addr <= m_adr;
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_decoder_n.sv
// Directed bench for wb_decoder_n: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.

module tb_wb_decoder_n;
  localparam int N  = 4;
  localparam int TO = 4;

  logic          clk, rst;
  logic [31:0]   m_adr, m_dat_o, m_dat_i, s_adr, s_dat_o, err_addr;
  logic          m_we, m_cyc, m_stb, m_ack, m_err, s_we;
  logic [N-1:0]  s_cyc, s_stb, s_ack;
  logic [N*32-1:0] s_dat_i;
  logic [7:0]    err_cnt;

  // slave 3 overlaps slave 0 so lowest-index priority is exercised
  wb_decoder_n #(
    .N_SLV(N), .ADDR_W(32), .DATA_W(32),
    .SLV_BASE({32'h00000000, 32'h00010004, 32'h00010000, 32'h00000000}),
    .SLV_MASK({32'hFFFF0000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFF0000}),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .m_adr(m_adr), .m_dat_o(m_dat_o), .m_we(m_we),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_dat_i(m_dat_i), .m_ack(m_ack), .m_err(m_err),
    .s_adr(s_adr), .s_dat_o(s_dat_o), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_dat_i(s_dat_i), .s_ack(s_ack), .err_addr(err_addr), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state: target slave of the open access (-1 none), cycles spent in it,
  // pending error-terminate cycle, and the error log
  int          tgt, age, e_cnt;
  bit          term;
  logic [31:0] e_addr;

  logic [31:0] base_t [N] = '{32'h00000000, 32'h00010000, 32'h00010004, 32'h00000000};
  logic [31:0] mask_t [N] = '{32'hFFFF0000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFF0000};

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & mask_t[i]) == base_t[i]) return i;
    return -1;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tgt = -1; age = 0; term = 0; e_addr = '0; e_cnt = 0;
  endtask

  task automatic compare();
    logic [N-1:0] x_cyc, x_stb;
    logic         x_ack, x_err;
    logic [31:0]  x_dat;
    bit           active;
    x_cyc = '0; x_stb = '0; x_ack = 0; x_err = 0; x_dat = '0;
    if (term) x_err = 1;
    else if (tgt >= 0) begin
      active = m_cyc && (age < TO);
      x_dat  = s_dat_i[tgt*32 +: 32];
      if (active) begin
        x_cyc[tgt] = 1'b1;
        x_stb[tgt] = m_stb;
        x_ack      = s_ack[tgt];
      end
    end
    check("m_ack", 64'(m_ack), 64'(x_ack));
    check("m_err", 64'(m_err), 64'(x_err));
    check("m_dat_i", 64'(m_dat_i), 64'(x_dat));
    check("s_cyc", 64'(s_cyc), 64'(x_cyc));
    check("s_stb", 64'(s_stb), 64'(x_stb));
    check("s_adr", 64'(s_adr), 64'(m_adr));
    check("s_dat_o", 64'(s_dat_o), 64'(m_dat_o));
    check("s_we", 64'(s_we), 64'(m_we));
    check("err_addr", 64'(err_addr), 64'(e_addr));
    check("err_cnt", 64'(err_cnt), 64'(e_cnt));
  endtask

  task automatic advance();
    if (!rst) return;
    if (term) begin
      e_addr = m_adr;
      if (e_cnt < 255) e_cnt++;
      term = 0;
    end else if (tgt >= 0) begin
      if (!m_cyc)            tgt = -1;
      else if (age >= TO)    begin tgt = -1; term = 1; end
      else if (s_ack[tgt])   tgt = -1;
      else                   age++;
    end else if (m_cyc && m_stb) begin
      tgt = decode(m_adr);
      age = 0;
      if (tgt < 0) term = 1;
    end
  endtask

  task automatic sample(); @(negedge clk); compare(); endtask
  task automatic tick();   @(posedge clk); advance(); #1; endtask
  task automatic step();   sample(); tick(); endtask

  task automatic idle_bus();
    m_cyc = 0; m_stb = 0; m_we = 0; s_ack = '0;
  endtask

  task automatic start(input logic [31:0] a, input logic we);
    m_adr = a; m_we = we; m_cyc = 1; m_stb = 1; s_ack = '0;
  endtask

  initial begin
    rst = 0; m_adr = '0; m_dat_o = '0; idle_bus();
    for (int i = 0; i < N; i++) s_dat_i[i*32 +: 32] = 32'h11111111 * (i + 1);
    s_dat_i[31:0] = 32'hA5A5A5A5;
    model_reset();
    step();
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_stb", 64'(s_stb), 64'd0);
    step();
    rst = 1;
    step();

    // read slave 0; slave 1 acks while unselected and must be ignored
    start(32'h00000010, 0);
    step();
    s_ack = 4'b0010;
    sample(); check("A_stray_ack", 64'(m_ack), 64'd0); check("A_stb", 64'(s_stb), 64'b0001); tick();
    step();
    s_ack = 4'b0001;
    sample();
    check("A_ack", 64'(m_ack), 64'd1);
    check("A_dat", 64'(m_dat_i), 64'hA5A5A5A5);
    check("A_stb_ack", 64'(s_stb), 64'b0001);
    tick();
    idle_bus(); step();

    // write slave 2 with immediate ack, then a back-to-back access to slave 1
    m_dat_o = 32'hDEADBEEF;
    start(32'h00010004, 1);
    step();
    s_ack = 4'b0100;
    sample();
    check("B_stb", 64'(s_stb), 64'b0100);
    check("B_ack", 64'(m_ack), 64'd1);
    check("B_err", 64'(m_err), 64'd0);
    tick();
    start(32'h00010000, 0);
    step();
    s_ack = 4'b0010;
    sample();
    check("B2_stb", 64'(s_stb), 64'b0010);
    check("B2_ack", 64'(m_ack), 64'd1);
    check("B2_dat", 64'(m_dat_i), 64'h22222222);
    tick();
    idle_bus(); step();

    // unmapped address
    start(32'h00020000, 0);
    step();
    sample();
    check("C_err", 64'(m_err), 64'd1);
    check("C_dat", 64'(m_dat_i), 64'd0);
    check("C_ack", 64'(m_ack), 64'd0);
    tick();
    idle_bus();
    sample();
    check("C_err_addr", 64'(err_addr), 64'h00020000);
    check("C_err_cnt", 64'(err_cnt), 64'd1);
    tick();

    // abort by dropping m_cyc, then a late ack
    start(32'h00000010, 0);
    step(); step();
    m_cyc = 0; m_stb = 0;
    sample(); check("D_stb", 64'(s_stb), 64'd0); check("D_cyc", 64'(s_cyc), 64'd0); tick();
    s_ack = 4'b0001;
    sample(); check("D_ack", 64'(m_ack), 64'd0); check("D_cnt", 64'(err_cnt), 64'd1); tick();
    idle_bus(); step();

    // async reset while BUSY
    start(32'h00000010, 0);
    step();
    rst = 0; #1;
    check("E_stb", 64'(s_stb), 64'd0);
    check("E_cyc", 64'(s_cyc), 64'd0);
    check("E_ack", 64'(m_ack), 64'd0);
    check("E_err", 64'(m_err), 64'd0);
    check("E_cnt", 64'(err_cnt), 64'd0);
    model_reset();
    step();
    rst = 1;
    step();
    s_ack = 4'b0001;
    sample(); check("E_post_ack", 64'(m_ack), 64'd1); check("E_post_stb", 64'(s_stb), 64'b0001); tick();
    idle_bus(); step();

    // timeout on slave 1, then repeated back-to-back until the counter saturates
    start(32'h00010000, 0);
    step();
    for (int k = 0; k < TO; k++) begin
      sample(); check("F_stb_hi", 64'(s_stb[1]), 64'd1); tick();
    end
    sample(); check("F_stb_lo", 64'(s_stb), 64'd0); check("F_err_early", 64'(m_err), 64'd0); tick();
    sample(); check("F_err", 64'(m_err), 64'd1); tick();
    for (int k = 1; k < 300; k++) repeat (TO + 3) step();
    idle_bus();
    sample();
    check("F_sat", 64'(err_cnt), 64'd255);
    check("F_err_addr", 64'(err_addr), 64'h00010000);
    tick();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
